collision_damage_gen: RTL and testbench
=======================================

Name: collision_damage_gen

Overview:
- Producer side of the damage interface: generates the single-cycle `updateHealth` pulse that the health counter consumes.
- Once per frame, when the main FSM enters its update-position state, scans all enemy slots for bounding-box overlap with the player.
- Reports the full collision mask, and issues at most one damage pulse per scan.
- An invulnerability window, counted in frames, suppresses repeated damage while contact persists.

Parameters:
- NUM_ENEMIES, 4, number of enemy slots scanned.
- COORD_W, 8, width of every x/y coordinate.
- PLAYER_SIZE, 8, player box edge in pixels (square).
- ENEMY_SIZE, 8, enemy box edge in pixels (square).
- INVULN_FRAMES, 30, frames of damage immunity after a hit.
- CNT_W, 5, invulnerability counter width (must hold INVULN_FRAMES).

Ports:
- clk  in  1  system clock; sole clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from main FSM on entering update-position state.
- frame_tick  in  1  one-cycle pulse per displayed frame.
- player_x  in  COORD_W  player top-left x.
- player_y  in  COORD_W  player top-left y.
- enemy_x  in  NUM_ENEMIES*COORD_W  packed enemy x; slot i at [i*COORD_W +: COORD_W].
- enemy_y  in  NUM_ENEMIES*COORD_W  packed enemy y, same packing.
- enemy_alive  in  NUM_ENEMIES  1 = slot active.
- busy  out  1  high in SCAN and REPORT.
- done  out  1  one-cycle pulse in REPORT.
- updateHealth  out  1  one-cycle damage pulse, coincident with done.
- hit_mask  out  NUM_ENEMIES  slots that overlapped in the last scan; valid from done until the next start.
- invulnerable  out  1  high while the invulnerability counter is non-zero.

Behaviour:
- Interface fixes: one clock `clk`; reset `reset`, synchronous, active-high.
- Reset values: state = IDLE; busy, done, updateHealth, invulnerable = 0; hit_mask = 0; scan index = 0; invulnerability counter = 0.
- Reset mid-scan: aborts to IDLE, no pulse is emitted, hit_mask is cleared.
- FSM states: IDLE, SCAN, REPORT.
- IDLE:
  - On start = 1: latch player_x and player_y.
  - Clear the working hit mask and set index = 0.
  - Go to SCAN.
- SCAN, one slot per cycle:
  - Slot i overlaps when all four hold: enemy_alive[i]; px < ex+ENEMY_SIZE; ex < px+PLAYER_SIZE; py < ey+ENEMY_SIZE; ey < py+PLAYER_SIZE.
  - Sums are computed at COORD_W+1 bits, so there is no wrap at screen edge (e.g. ex = 250 + 8 = 258 is valid).
  - Dead slots still consume a cycle and never hit.
  - After index NUM_ENEMIES-1, go to REPORT.
- Enemy inputs are sampled live during SCAN; player position is the latched value.
- REPORT, exactly one cycle:
  - done = 1; hit_mask <= working mask.
  - updateHealth = 1 iff the working mask is non-zero and the invulnerability counter == 0.
  - When updateHealth fires, the counter loads INVULN_FRAMES.
  - Next state IDLE.
- Latency: start at cycle T gives SCAN during T+1..T+NUM_ENEMIES and REPORT at T+NUM_ENEMIES+1. The main FSM must remain in update-position through that cycle, because the consumer gates on it.
- start while busy is ignored; it is not queued.
- Invulnerability counter:
  - Decrements by 1 on frame_tick when non-zero; saturates at 0.
  - Load in REPORT takes priority over a same-cycle frame_tick.
  - invulnerable = (counter != 0), registered with the counter.
- Multiple simultaneous overlaps produce one pulse, never more than one per scan.

Test Plan:
- Reset, then start with player (10,10) and all slots dead -> done at cycle T+5, updateHealth = 0, hit_mask = 0000, busy high for exactly 5 cycles.
- Player (10,10), slot 2 alive at (14,12), others dead -> REPORT: hit_mask = 0100, updateHealth = 1 for one cycle, invulnerable = 1 next cycle.
- Repeat the previous overlap on the next frame with fewer than 30 frame_ticks elapsed -> hit_mask = 0100, updateHealth = 0. After 30 ticks, the next scan gives updateHealth = 1.
- Edge and wrap: player (0,0), enemy (8,0) -> no hit (touching edges). Player (250,250), enemy (252,252) -> hit, with no wrap false-negative.
- Slots 0 and 3 overlapping simultaneously -> hit_mask = 1001, exactly one updateHealth pulse. A second start issued mid-scan -> ignored.
- Assert reset during SCAN cycle 2 -> next cycle busy = 0, hit_mask = 0, updateHealth never asserted. frame_tick coinciding with REPORT load -> counter reads INVULN_FRAMES.

Source files
------------

// File: rtl/collision_damage_gen.sv
// Per-frame player/enemy bounding-box scan that produces the collision mask and
// at most one damage pulse per scan, with a frame-counted invulnerability window.
module collision_damage_gen #(
    parameter int NUM_ENEMIES   = 4,
    parameter int COORD_W       = 8,
    parameter int PLAYER_SIZE   = 8,
    parameter int ENEMY_SIZE    = 8,
    parameter int INVULN_FRAMES = 30,
    parameter int CNT_W         = 5
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           frame_tick,
    input  logic [COORD_W-1:0]             player_x,
    input  logic [COORD_W-1:0]             player_y,
    input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_x,
    input  logic [NUM_ENEMIES*COORD_W-1:0] enemy_y,
    input  logic [NUM_ENEMIES-1:0]         enemy_alive,
    output logic                           busy,
    output logic                           done,
    output logic                           updateHealth,
    output logic [NUM_ENEMIES-1:0]         hit_mask,
    output logic                           invulnerable
);
    localparam int IDX_W = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_ENEMIES - 1);
    localparam logic [COORD_W:0]   PSZ      = (COORD_W + 1)'(PLAYER_SIZE);
    localparam logic [COORD_W:0]   ESZ      = (COORD_W + 1)'(ENEMY_SIZE);
    localparam logic [CNT_W-1:0]   INV_LOAD = CNT_W'(INVULN_FRAMES);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [COORD_W-1:0]     px_q, py_q;
    logic [NUM_ENEMIES-1:0] work_mask, mask_nx;
    logic [CNT_W-1:0]       cnt, cnt_nx;
    logic [COORD_W:0]       px_w, py_w, ex_w, ey_w;
    logic                   overlap;

    // One extra bit on every operand so boxes near the screen edge never wrap.
    always_comb begin
        px_w    = {1'b0, px_q};
        py_w    = {1'b0, py_q};
        ex_w    = {1'b0, enemy_x[idx*COORD_W +: COORD_W]};
        ey_w    = {1'b0, enemy_y[idx*COORD_W +: COORD_W]};
        overlap = enemy_alive[idx] &&
                  (px_w < ex_w + ESZ) && (ex_w < px_w + PSZ) &&
                  (py_w < ey_w + ESZ) && (ey_w < py_w + PSZ);
        mask_nx      = work_mask;
        mask_nx[idx] = overlap;
    end

    // A damage load wins over a coincident frame tick.
    always_comb begin
        cnt_nx = cnt;
        if (state == REPORT && updateHealth)
            cnt_nx = INV_LOAD;
        else if (frame_tick && cnt != '0)
            cnt_nx = cnt - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            px_q         <= '0;
            py_q         <= '0;
            work_mask    <= '0;
            hit_mask     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            updateHealth <= 1'b0;
            cnt          <= '0;
            invulnerable <= 1'b0;
        end else begin
            done         <= 1'b0;
            updateHealth <= 1'b0;
            cnt          <= cnt_nx;
            invulnerable <= (cnt_nx != '0);
            case (state)
                IDLE: begin
                    if (start) begin
                        px_q      <= player_x;
                        py_q      <= player_y;
                        work_mask <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    work_mask <= mask_nx;
                    if (idx == LAST_IDX) begin
                        // Decide using the counter value REPORT will actually see.
                        state        <= REPORT;
                        done         <= 1'b1;
                        hit_mask     <= mask_nx;
                        updateHealth <= (mask_nx != '0) && (cnt_nx == '0);
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_collision_damage_gen.sv
// Scoreboard bench for collision_damage_gen: expected scan results are queued
// at start time and compared when done is seen.
module tb_collision_damage_gen;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int SZ  = 8;
    localparam int INV = 30;

    logic             clk = 1'b0;
    logic             reset, start, frame_tick;
    logic [W-1:0]     player_x, player_y;
    logic [N*W-1:0]   enemy_x, enemy_y;
    logic [N-1:0]     enemy_alive;
    logic             busy, done, updateHealth, invulnerable;
    logic [N-1:0]     hit_mask;

    typedef struct {
        logic [N-1:0] mask;
        logic         upd;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_cnt = 0;

    collision_damage_gen dut (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .player_x(player_x), .player_y(player_y),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_alive(enemy_alive),
        .busy(busy), .done(done), .updateHealth(updateHealth),
        .hit_mask(hit_mask), .invulnerable(invulnerable)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_enemy(input int i, input int x, input int y, input bit alive);
        enemy_x[i*W +: W] = W'(x);
        enemy_y[i*W +: W] = W'(y);
        enemy_alive[i]    = alive;
    endtask

    task automatic kill_all();
        for (int i = 0; i < N; i++) set_enemy(i, 200, 200, 1'b0);
    endtask

    function automatic logic [N-1:0] model_mask();
        logic [N-1:0] m;
        int px, py, ex, ey;
        m  = '0;
        px = int'(player_x);
        py = int'(player_y);
        for (int i = 0; i < N; i++) begin
            ex = int'(enemy_x[i*W +: W]);
            ey = int'(enemy_y[i*W +: W]);
            m[i] = enemy_alive[i] && (px < ex + SZ) && (ex < px + SZ) &&
                   (py < ey + SZ) && (ey < py + SZ);
        end
        return m;
    endfunction

    task automatic push_expect();
        exp_t e;
        e.mask = model_mask();
        e.upd  = (e.mask != '0) && (model_cnt == 0);
        if (e.upd) model_cnt = INV;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        tick(); tick();
        reset = 1'b0;
        model_cnt = 0;
        sb.delete();
    endtask

    task automatic frame_pulse();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        if (model_cnt > 0) model_cnt--;
    endtask

    // Drives one scan and records what the DUT produced; no judging here.
    task automatic observe(input int ncyc, input int restart_at, input int tick_at,
                           output int done_at, output int done_cnt, output int upd_cnt,
                           output int busy_cnt, output logic [N-1:0] m, output logic u,
                           output logic inv_after);
        done_at = 0; done_cnt = 0; upd_cnt = 0; busy_cnt = 0;
        m = '0; u = 1'b0; inv_after = 1'b0;
        push_expect();
        start = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            start      = (k == restart_at);
            frame_tick = (k == tick_at);
            if (busy === 1'b1) busy_cnt++;
            if (updateHealth === 1'b1) upd_cnt++;
            if (done_at != 0 && k == done_at + 1) inv_after = invulnerable;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = k;
                    m = hit_mask;
                    u = updateHealth;
                end
            end
        end
        start = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (updateHealth !== 1'b0) begin n_err++; $display("FAIL reset_upd: got %b expected 0", updateHealth); end
        n_cmp++; if (hit_mask !== 4'b0000) begin n_err++; $display("FAIL reset_mask: got %b expected 0000", hit_mask); end
        n_cmp++; if (invulnerable !== 1'b0) begin n_err++; $display("FAIL reset_inv: got %b expected 0", invulnerable); end
    endtask

    task automatic test_all_dead();
        int da, dc, uc, bc; logic [N-1:0] m; logic u, ia; exp_t e;
        player_x = 8'd10; player_y = 8'd10;
        kill_all();
        observe(8, 0, 0, da, dc, uc, bc, m, u, ia);
        e = sb.pop_front();
        n_cmp++; if (da != 5) begin n_err++; $display("FAIL dead_latency: got %0d expected 5", da); end
        n_cmp++; if (bc != 5) begin n_err++; $display("FAIL dead_busy_cycles: got %0d expected 5", bc); end
        n_cmp++; if (dc != 1) begin n_err++; $display("FAIL dead_done_count: got %0d expected 1", dc); end
        n_cmp++; if (m !== e.mask) begin n_err++; $display("FAIL dead_mask: got %b expected %b", m, e.mask); end
        n_cmp++; if (u !== e.upd) begin n_err++; $display("FAIL dead_upd: got %b expected %b", u, e.upd); end
    endtask

    task automatic test_single_hit();
        int da, dc, uc, bc; logic [N-1:0] m; logic u, ia; exp_t e;
        player_x = 8'd10; player_y = 8'd10;
        kill_all();
        set_enemy(2, 14, 12, 1'b1);
        observe(8, 0, 0, da, dc, uc, bc, m, u, ia);
        e = sb.pop_front();
        n_cmp++; if (m !== e.mask) begin n_err++; $display("FAIL single_mask: got %b expected %b", m, e.mask); end
        n_cmp++; if (u !== e.upd) begin n_err++; $display("FAIL single_upd: got %b expected %b", u, e.upd); end
        n_cmp++; if (uc != 1) begin n_err++; $display("FAIL single_upd_width: got %0d expected 1", uc); end
        n_cmp++; if (ia !== 1'b1) begin n_err++; $display("FAIL single_inv_next: got %b expected 1", ia); end
    endtask

    task automatic test_invuln();
        int da, dc, uc, bc; logic [N-1:0] m; logic u, ia; exp_t e;
        observe(8, 0, 0, da, dc, uc, bc, m, u, ia);
        e = sb.pop_front();
        n_cmp++; if (m !== e.mask) begin n_err++; $display("FAIL inv_repeat_mask: got %b expected %b", m, e.mask); end
        n_cmp++; if (u !== e.upd) begin n_err++; $display("FAIL inv_repeat_upd: got %b expected %b", u, e.upd); end
        for (int i = 0; i < INV - 1; i++) frame_pulse();
        n_cmp++; if (invulnerable !== (model_cnt != 0)) begin n_err++; $display("FAIL inv_29_ticks: got %b expected %b", invulnerable, model_cnt != 0); end
        observe(8, 0, 0, da, dc, uc, bc, m, u, ia);
        e = sb.pop_front();
        n_cmp++; if (u !== e.upd) begin n_err++; $display("FAIL inv_29_upd: got %b expected %b", u, e.upd); end
        frame_pulse();
        n_cmp++; if (invulnerable !== (model_cnt != 0)) begin n_err++; $display("FAIL inv_30_ticks: got %b expected %b", invulnerable, model_cnt != 0); end
        observe(8, 0, 0, da, dc, uc, bc, m, u, ia);
        e = sb.pop_front();
        n_cmp++; if (u !== e.upd) begin n_err++; $display("FAIL inv_30_upd: got %b expected %b", u, e.upd); end
    endtask

    task automatic test_edges();
        int da, dc, uc, bc; logic [N-1:0] m; logic u, ia; exp_t e;
        do_reset();
        player_x = 8'd0; player_y = 8'd0;
        kill_all();
        set_enemy(0, 8, 0, 1'b1);
        set_enemy(1, 0, 8, 1'b1);
        observe(8, 0, 0, da, dc, uc, bc, m, u, ia);
        e = sb.pop_front();
        n_cmp++; if (m !== e.mask) begin n_err++; $display("FAIL edge_touch_mask: got %b expected %b", m, e.mask); end
        n_cmp++; if (u !== e.upd) begin n_err++; $display("FAIL edge_touch_upd: got %b expected %b", u, e.upd); end
        player_x = 8'd250; player_y = 8'd250;
        kill_all();
        set_enemy(1, 252, 252, 1'b1);
        observe(8, 0, 0, da, dc, uc, bc, m, u, ia);
        e = sb.pop_front();
        n_cmp++; if (m !== e.mask) begin n_err++; $display("FAIL edge_wrap_mask: got %b expected %b", m, e.mask); end
        n_cmp++; if (u !== e.upd) begin n_err++; $display("FAIL edge_wrap_upd: got %b expected %b", u, e.upd); end
    endtask

    task automatic setup_multi();
        player_x = 8'd50; player_y = 8'd50;
        set_enemy(0, 45, 45, 1'b1);
        set_enemy(1, 100, 100, 1'b1);
        set_enemy(2, 10, 200, 1'b1);
        set_enemy(3, 55, 56, 1'b1);
    endtask

    task automatic test_multi_hit();
        int da, dc, uc, bc; logic [N-1:0] m; logic u, ia; exp_t e;
        do_reset();
        setup_multi();
        observe(12, 2, 0, da, dc, uc, bc, m, u, ia);
        e = sb.pop_front();
        n_cmp++; if (m !== e.mask) begin n_err++; $display("FAIL multi_mask: got %b expected %b", m, e.mask); end
        n_cmp++; if (u !== e.upd) begin n_err++; $display("FAIL multi_upd: got %b expected %b", u, e.upd); end
        n_cmp++; if (uc != 1) begin n_err++; $display("FAIL multi_upd_count: got %0d expected 1", uc); end
        n_cmp++; if (dc != 1) begin n_err++; $display("FAIL multi_restart_ignored: got %0d dones expected 1", dc); end
        n_cmp++; if (da != 5) begin n_err++; $display("FAIL multi_latency: got %0d expected 5", da); end
    endtask

    task automatic test_reset_mid_scan();
        int dc, uc;
        for (int i = 0; i < INV; i++) frame_pulse();
        setup_multi();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_cnt = 0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++; if (hit_mask !== 4'b0000) begin n_err++; $display("FAIL midrst_mask: got %b expected 0000", hit_mask); end
        dc = 0; uc = 0;
        for (int k = 0; k < 8; k++) begin
            if (done === 1'b1) dc++;
            if (updateHealth === 1'b1) uc++;
            tick();
        end
        n_cmp++; if (uc != 0) begin n_err++; $display("FAIL midrst_upd: got %0d pulses expected 0", uc); end
        n_cmp++; if (dc != 0) begin n_err++; $display("FAIL midrst_done: got %0d pulses expected 0", dc); end
    endtask

    task automatic test_tick_on_load();
        int da, dc, uc, bc; logic [N-1:0] m; logic u, ia; exp_t e;
        do_reset();
        player_x = 8'd10; player_y = 8'd10;
        kill_all();
        set_enemy(2, 14, 12, 1'b1);
        observe(8, 0, 5, da, dc, uc, bc, m, u, ia);
        e = sb.pop_front();
        n_cmp++; if (u !== e.upd) begin n_err++; $display("FAIL load_upd: got %b expected %b", u, e.upd); end
        for (int i = 0; i < INV - 1; i++) frame_pulse();
        n_cmp++; if (invulnerable !== (model_cnt != 0)) begin n_err++; $display("FAIL load_priority: got %b expected %b", invulnerable, model_cnt != 0); end
        frame_pulse();
        n_cmp++; if (invulnerable !== (model_cnt != 0)) begin n_err++; $display("FAIL load_expire: got %b expected %b", invulnerable, model_cnt != 0); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; frame_tick = 1'b0;
        player_x = '0; player_y = '0;
        enemy_x = '0; enemy_y = '0; enemy_alive = '0;
        test_reset();
        test_all_dead();
        test_single_hit();
        test_invuln();
        test_edges();
        test_multi_hit();
        test_reset_mid_scan();
        test_tick_on_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
